// File: rtl/cdb_buffered_arbiter_pkg.sv
// Shared CDB payload type and system defaults for the buffered CDB arbiter.
// Supplies fallback values for `N and `NUM_FU_TOTAL when no system header defines them.
`ifndef N
`define N 2
`endif
`ifndef NUM_FU_TOTAL
`define NUM_FU_TOTAL 4
`endif

package cdb_buffered_arbiter_pkg;

    localparam int unsigned CDB_TAG_W  = 6;
    localparam int unsigned CDB_DATA_W = 32;

    typedef struct packed {
        logic                  valid;
        logic [CDB_TAG_W-1:0]  tags;
        logic [CDB_DATA_W-1:0] data;
    } CDB_ENTRY;

endpackage

// File: rtl/cdb_src_fifo.sv
// Per-source circular result buffer with non-power-of-two wrap and synchronous squash.
module cdb_src_fifo
    import cdb_buffered_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic     clock,
    input  logic     reset,
    input  logic     squash,
    input  logic     push,
    input  CDB_ENTRY push_entry,
    input  logic     pop,
    output CDB_ENTRY head,
    output logic     full,
    output logic     empty
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

    CDB_ENTRY          mem [DEPTH];
    logic [IDX_W-1:0]  rd_idx;
    logic [IDX_W-1:0]  wr_idx;
    logic [CNT_W-1:0]  count;
    logic              do_push;
    logic              do_pop;

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
        return (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
    endfunction

    assign full    = (count == DEPTH_CNT);
    assign empty   = (count == '0);
    assign do_push = push && !full && !squash;
    assign do_pop  = pop && !empty && !squash;
    assign head    = mem[rd_idx];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_idx <= '0;
            wr_idx <= '0;
            count  <= '0;
        end else if (squash) begin
            rd_idx <= '0;
            wr_idx <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_idx <= next_idx(wr_idx);
            if (do_pop)  rd_idx <= next_idx(rd_idx);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Payload storage needs no reset; occupancy is tracked by count.
    always_ff @(posedge clock) begin
        if (do_push) mem[wr_idx] <= push_entry;
    end

endmodule

// File: rtl/cdb_buffered_arbiter.sv
// Buffered CDB arbiter: per-FU result buffers feeding NUM_CDB registered broadcast lanes.
// `CDB_ARB_RR_EN selects round-robin scan; otherwise fixed priority from source 0.
module cdb_buffered_arbiter
    import cdb_buffered_arbiter_pkg::*;
#(
    parameter int unsigned NUM_SRC   = `NUM_FU_TOTAL,
    parameter int unsigned NUM_CDB   = `N,
    parameter int unsigned BUF_DEPTH = 2
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               squash,
    input  CDB_ENTRY           fu_outputs [NUM_SRC-1:0],
    output logic [NUM_SRC-1:0] fu_ready,
    output CDB_ENTRY           cdb_output [NUM_CDB-1:0],
    output logic               all_empty
);

    localparam int unsigned SRC_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    CDB_ENTRY           heads     [NUM_SRC-1:0];
    logic [NUM_SRC-1:0] full;
    logic [NUM_SRC-1:0] empty;
    logic [NUM_SRC-1:0] grant;
    logic [SRC_W-1:0]   scan_start;
    logic [SRC_W-1:0]   lane_sel  [NUM_CDB-1:0];
    logic [NUM_CDB-1:0] lane_vld;
    CDB_ENTRY           lane_next [NUM_CDB-1:0];
    logic               lane_any_valid;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        cdb_src_fifo #(
            .DEPTH(BUF_DEPTH)
        ) u_fifo (
            .clock      (clock),
            .reset      (reset),
            .squash     (squash),
            .push       (fu_outputs[i].valid),
            .push_entry (fu_outputs[i]),
            .pop        (grant[i]),
            .head       (heads[i]),
            .full       (full[i]),
            .empty      (empty[i])
        );
    end

    assign fu_ready = ~full;

    // Rotating scan from scan_start; the first NUM_CDB non-empty heads take lanes in order.
    always_comb begin : arbitrate
        int unsigned n_grant;
        int unsigned scan;
        grant    = '0;
        lane_vld = '0;
        n_grant  = 0;
        scan     = 0;
        for (int unsigned k = 0; k < NUM_CDB; k++) lane_sel[k] = '0;
        for (int unsigned j = 0; j < NUM_SRC; j++) begin
            scan = 32'(scan_start) + j;
            if (scan >= NUM_SRC) scan = scan - NUM_SRC;
            if (!empty[SRC_W'(scan)] && (n_grant < NUM_CDB)) begin
                grant[SRC_W'(scan)] = 1'b1;
                for (int unsigned k = 0; k < NUM_CDB; k++) begin
                    if (k == n_grant) begin
                        lane_sel[k] = SRC_W'(scan);
                        lane_vld[k] = 1'b1;
                    end
                end
                n_grant = n_grant + 1;
            end
        end
    end

`ifdef CDB_ARB_RR_EN
    logic [SRC_W-1:0] rr_ptr;
    logic [SRC_W-1:0] last_sel;
    logic [SRC_W-1:0] rr_next;

    // Highest-numbered valid lane holds the last source in scan order.
    always_comb begin
        last_sel = rr_ptr;
        for (int unsigned k = 0; k < NUM_CDB; k++) begin
            if (lane_vld[k]) last_sel = lane_sel[k];
        end
        rr_next = (32'(last_sel) == NUM_SRC - 1) ? '0 : last_sel + SRC_W'(1);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rr_ptr <= '0;
        end else if (!squash && (|grant)) begin
            rr_ptr <= rr_next;
        end
    end

    assign scan_start = rr_ptr;
`else
    assign scan_start = '0;
`endif

    always_comb begin
        for (int unsigned k = 0; k < NUM_CDB; k++) begin
            lane_next[k] = '0;
            if (lane_vld[k]) begin
                lane_next[k]       = heads[lane_sel[k]];
                lane_next[k].valid = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int unsigned k = 0; k < NUM_CDB; k++) cdb_output[k] <= '0;
        end else if (squash) begin
            for (int unsigned k = 0; k < NUM_CDB; k++) cdb_output[k] <= '0;
        end else begin
            for (int unsigned k = 0; k < NUM_CDB; k++) cdb_output[k] <= lane_next[k];
        end
    end

    always_comb begin
        lane_any_valid = 1'b0;
        for (int unsigned k = 0; k < NUM_CDB; k++) begin
            lane_any_valid = lane_any_valid | cdb_output[k].valid;
        end
    end

    assign all_empty = (&empty) && !lane_any_valid;

endmodule

// File: tb/tb_cdb_buffered_arbiter.sv
// Randomized self-checking bench for cdb_buffered_arbiter against a queue-based reference model.
module tb_cdb_buffered_arbiter;
    import cdb_buffered_arbiter_pkg::*;

    localparam int NUM_SRC   = 4;
    localparam int NUM_CDB   = 2;
    localparam int BUF_DEPTH = 2;

    logic               clock = 1'b0;
    logic               reset;
    logic               squash;
    CDB_ENTRY           fu_outputs [NUM_SRC-1:0];
    logic [NUM_SRC-1:0] fu_ready;
    CDB_ENTRY           cdb_output [NUM_CDB-1:0];
    logic               all_empty;

    cdb_buffered_arbiter #(
        .NUM_SRC   (NUM_SRC),
        .NUM_CDB   (NUM_CDB),
        .BUF_DEPTH (BUF_DEPTH)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .squash     (squash),
        .fu_outputs (fu_outputs),
        .fu_ready   (fu_ready),
        .cdb_output (cdb_output),
        .all_empty  (all_empty)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: per-source FIFO queues, expected lane contents, scan pointer.
    CDB_ENTRY q [NUM_SRC][$];
    CDB_ENTRY exp_lane [NUM_CDB];
    int       rr = 0;
    int       n_acc = 0;
    int       n_dut_bcast = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NUM_SRC; i++) q[i].delete();
        for (int k = 0; k < NUM_CDB; k++) exp_lane[k] = '0;
        rr = 0;
    endtask

    task automatic set_idle();
        squash = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) fu_outputs[i] = '0;
    endtask

    task automatic drive_src(input int i, input logic [CDB_TAG_W-1:0] t, input logic [CDB_DATA_W-1:0] d);
        fu_outputs[i].valid = 1'b1;
        fu_outputs[i].tags  = t;
        fu_outputs[i].data  = d;
    endtask

    task automatic rand_drive(input int pct);
        for (int i = 0; i < NUM_SRC; i++) begin
            if (int'($urandom_range(0, 99)) < pct)
                drive_src(i, CDB_TAG_W'($urandom), $urandom);
            else
                fu_outputs[i] = '0;
        end
    endtask

    task automatic check_model();
        logic [NUM_SRC-1:0] rdy;
        logic               emp;
        emp = 1'b1;
        for (int i = 0; i < NUM_SRC; i++) begin
            rdy[i] = (q[i].size() < BUF_DEPTH);
            if (q[i].size() != 0) emp = 1'b0;
        end
        for (int k = 0; k < NUM_CDB; k++) begin
            check_eq($sformatf("lane%0d", k), 64'(cdb_output[k]), 64'(exp_lane[k]));
            if (exp_lane[k].valid) emp = 1'b0;
        end
        check_eq("fu_ready", 64'(fu_ready), 64'(rdy));
        check_eq("all_empty", 64'(all_empty), 64'(emp));
    endtask

    // Advance one clock: model applies arbitration on current queues, then accepts pushes.
    task automatic step();
        CDB_ENTRY nl [NUM_CDB];
        bit       rdy [NUM_SRC];
        int       g, last, start, s;
        for (int i = 0; i < NUM_SRC; i++) rdy[i] = (q[i].size() < BUF_DEPTH);
        for (int k = 0; k < NUM_CDB; k++) nl[k] = '0;
        if (squash) begin
            for (int i = 0; i < NUM_SRC; i++) q[i].delete();
        end else begin
`ifdef CDB_ARB_RR_EN
            start = rr;
`else
            start = 0;
`endif
            g = 0;
            last = -1;
            for (int j = 0; j < NUM_SRC; j++) begin
                s = (start + j) % NUM_SRC;
                if (q[s].size() > 0 && g < NUM_CDB) begin
                    nl[g] = q[s].pop_front();
                    nl[g].valid = 1'b1;
                    g++;
                    last = s;
                end
            end
            if (last >= 0) rr = (last + 1) % NUM_SRC;
            for (int i = 0; i < NUM_SRC; i++) begin
                if (fu_outputs[i].valid && rdy[i]) begin
                    q[i].push_back(fu_outputs[i]);
                    n_acc++;
                end
            end
        end
        @(posedge clock);
        #1;
        for (int k = 0; k < NUM_CDB; k++) exp_lane[k] = nl[k];
        for (int k = 0; k < NUM_CDB; k++) if (cdb_output[k].valid) n_dut_bcast++;
        check_model();
    endtask

    initial begin
        CDB_ENTRY e;
        int       first_seen;
        bit       seen3;

        reset = 1'b1;
        set_idle();
        model_reset();
        #1;
        check_eq("rst_lane0", 64'(cdb_output[0]), 64'd0);
        check_eq("rst_lane1", 64'(cdb_output[1]), 64'd0);
        check_eq("rst_ready", 64'(fu_ready), 64'hF);
        check_eq("rst_all_empty", 64'(all_empty), 64'd1);
        @(posedge clock);
        #1;
        reset = 1'b0;

        // Single result from src2
        drive_src(2, 6'd7, 32'hAB);
        step();
        set_idle();
        step();
        e = '{valid: 1'b1, tags: 6'd7, data: 32'hAB};
        check_eq("single_lane0", 64'(cdb_output[0]), 64'(e));
        check_eq("single_lane1", 64'(cdb_output[1]), 64'd0);
        step();
        check_eq("single_all_empty", 64'(all_empty), 64'd1);

        // Rotation from a fresh pointer
        reset = 1'b1;
        #1;
        model_reset();
        @(posedge clock);
        #1;
        reset = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) drive_src(i, CDB_TAG_W'(i), 32'(100 + i));
        step();
        set_idle();
        step();
        for (int k = 0; k < NUM_CDB; k++) begin
            e = '{valid: 1'b1, tags: CDB_TAG_W'(k), data: 32'(100 + k)};
            check_eq($sformatf("rot_c2_lane%0d", k), 64'(cdb_output[k]), 64'(e));
        end
        step();
        for (int k = 0; k < NUM_CDB; k++) begin
            e = '{valid: 1'b1, tags: CDB_TAG_W'(k + 2), data: 32'(102 + k)};
            check_eq($sformatf("rot_c3_lane%0d", k), 64'(cdb_output[k]), 64'(e));
        end
        step();

        // Backpressure: everyone pushes every cycle, then drain
        n_acc = 0;
        n_dut_bcast = 0;
        for (int c = 0; c < 20; c++) begin
            rand_drive(100);
            step();
        end
        set_idle();
        for (int c = 0; c < 12; c++) step();
        check_eq("bp_count", 64'(n_dut_bcast), 64'(n_acc));

        // Squash with results buffered; the squash-cycle push must vanish
        for (int c = 0; c < 3; c++) begin
            rand_drive(100);
            step();
        end
        set_idle();
        squash = 1'b1;
        drive_src(0, 6'h3F, 32'hDEAD_BEEF);
        step();
        set_idle();
        check_eq("sq_lane0", 64'(cdb_output[0]), 64'd0);
        check_eq("sq_lane1", 64'(cdb_output[1]), 64'd0);
        check_eq("sq_ready", 64'(fu_ready), 64'hF);
        check_eq("sq_all_empty", 64'(all_empty), 64'd1);
        for (int c = 0; c < 3; c++) step();

        // Random traffic with occasional squash
        for (int c = 0; c < 300; c++) begin
            rand_drive(55);
            squash = ($urandom_range(0, 39) == 0);
            step();
        end
        set_idle();

        // Asynchronous reset between edges
        for (int c = 0; c < 4; c++) begin
            rand_drive(100);
            step();
        end
        #3;
        reset = 1'b1;
        #1;
        check_eq("arst_lane0", 64'(cdb_output[0]), 64'd0);
        check_eq("arst_lane1", 64'(cdb_output[1]), 64'd0);
        check_eq("arst_ready", 64'(fu_ready), 64'hF);
        check_eq("arst_all_empty", 64'(all_empty), 64'd1);
        model_reset();
        set_idle();
        @(posedge clock);
        @(posedge clock);
        #2;
        reset = 1'b0;
        for (int c = 0; c < 4; c++) step();

        // src0, src1, src3 continuously valid: starvation vs rotation
        seen3 = 1'b0;
        first_seen = 0;
        for (int p = 1; p <= 30; p++) begin
            fu_outputs[2] = '0;
            drive_src(0, 6'd0, {8'h00, 24'($urandom)});
            drive_src(1, 6'd1, {8'h01, 24'($urandom)});
            drive_src(3, 6'd3, {8'h03, 24'($urandom)});
            step();
            for (int k = 0; k < NUM_CDB; k++) begin
                if (cdb_output[k].valid && cdb_output[k].data[31:24] == 8'h03 && !seen3) begin
                    seen3 = 1'b1;
                    first_seen = p;
                end
            end
        end
`ifdef CDB_ARB_RR_EN
        check_eq("rr_src3_seen", 64'(seen3), 64'd1);
        check_eq("rr_src3_latency_ok", 64'(first_seen >= 1 && first_seen <= 3), 64'd1);
`else
        check_eq("fp_src3_starved", 64'(seen3), 64'd0);
`endif
        set_idle();
        for (int c = 0; c < 6; c++) step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
